// File: rtl/decompress_1_pkg.sv
// Shared constants, state encoding and coefficient helper for decompress_1.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package decompress_1_pkg;

    localparam int          N_BYTES = 32;
    localparam int          N_PAIRS = 128;
    localparam logic [15:0] HALF_Q  = 16'd1665;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        OUT  = 2'd2,
        DONE = 2'd3
    } state_t;

    // One message bit maps to either 0 or round(q/2).
    function automatic logic [15:0] coeff(input logic b);
        return b ? HALF_Q : 16'd0;
    endfunction

endpackage

// File: rtl/decompress_1_msg_buffer.sv
// 32x8 message store: one synchronous write port, one combinational read port.
// Latency: write lands on the clock edge, read is same-cycle combinational.
// Backpressure: none; writes are accepted every cycle wr_en is high.
module msg_buffer
    import decompress_1_pkg::*;
(
    input  logic       clk,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data
);

    logic [7:0] mem [N_BYTES];

    // Contents are not reset; the producer always reloads before a run.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/decompress_1.sv
// 1-bit message decompression: 32 loaded bytes -> 128 coefficient pairs (bit ? 1665 : 0).
// Latency: byte written one cycle after its request; first pair valid the cycle after OUT entry.
// Backpressure: readout low holds the current pair; optional DECOMPRESS_1_AUTO_RESTART_EN re-arms LOAD after DONE.
module decompress_1
    import decompress_1_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        set,
    input  logic        readin,
    input  logic        readout,
    input  logic        full_in,
    input  logic [7:0]  decomp_din,
    input  logic [7:0]  in_index,
    output logic [15:0] decomp_dout_1,
    output logic [15:0] decomp_dout_2,
    output logic [7:0]  out_index,
    output logic        readin_ok,
    output logic        readout_ok,
    output logic        done
);

    state_t     state;
    logic       take;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [6:0] next_k;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] byte_sel;
    logic       bit_lo;
    logic       bit_hi;
    logic       last_byte;

    // The data phase of an accepted request writes the byte; upper index bits wrap.
    assign wr_en     = take;
    assign wr_addr   = in_index[4:0];
    assign last_byte = take && full_in && (state == LOAD);

    msg_buffer u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (decomp_din),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Pair to be presented after the coming edge: pair 0 on OUT entry, else the successor.
    always_comb begin
        next_k = 7'd0;
        if (state == OUT) begin
            next_k = out_index[6:0] + 7'd1;
        end
    end

    assign rd_addr = next_k[6:2];

    // Forward the byte being written this cycle so the final byte is visible to pair 0.
    assign byte_sel = (wr_en && (wr_addr == rd_addr)) ? decomp_din : rd_data;
    assign bit_lo   = byte_sel[{next_k[1:0], 1'b0}];
    assign bit_hi   = byte_sel[{next_k[1:0], 1'b1}];

    // Control FSM with registered handshake flags and output pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            take          <= 1'b0;
            out_index     <= 8'd0;
            decomp_dout_1 <= 16'd0;
            decomp_dout_2 <= 16'd0;
            readin_ok     <= 1'b0;
            readout_ok    <= 1'b0;
            done          <= 1'b0;
        end else begin
            take <= readin && readin_ok && set && !last_byte;
            if (!set) begin
                state      <= IDLE;
                out_index  <= 8'd0;
                readin_ok  <= 1'b0;
                readout_ok <= 1'b0;
                done       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state     <= LOAD;
                        readin_ok <= 1'b1;
                    end
                    LOAD: begin
                        if (last_byte) begin
                            state         <= OUT;
                            readin_ok     <= 1'b0;
                            readout_ok    <= 1'b1;
                            out_index     <= 8'd0;
                            decomp_dout_1 <= coeff(bit_lo);
                            decomp_dout_2 <= coeff(bit_hi);
                        end
                    end
                    OUT: begin
                        if (readout && readout_ok) begin
                            if (out_index == 8'(N_PAIRS - 1)) begin
                                state      <= DONE;
                                readout_ok <= 1'b0;
                                done       <= 1'b1;
                            end else begin
                                out_index     <= out_index + 8'd1;
                                decomp_dout_1 <= coeff(bit_lo);
                                decomp_dout_2 <= coeff(bit_hi);
                            end
                        end
                    end
                    DONE: begin
`ifdef DECOMPRESS_1_AUTO_RESTART_EN
                        state     <= LOAD;
                        done      <= 1'b0;
                        out_index <= 8'd0;
                        readin_ok <= 1'b1;
`else
                        state <= DONE;
`endif
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_decompress_1.sv
module tb_decompress_1;

    logic        clk = 1'b0;
    logic        reset;
    logic        set;
    logic        readin;
    logic        readout;
    logic        full_in;
    logic [7:0]  decomp_din;
    logic [7:0]  in_index;
    logic [15:0] decomp_dout_1;
    logic [15:0] decomp_dout_2;
    logic [7:0]  out_index;
    logic        readin_ok;
    logic        readout_ok;
    logic        done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          idx;
        logic [15:0] d1;
        logic [15:0] d2;
    } pair_t;

    pair_t      sb[$];
    logic [7:0] model_mem [32];
    logic [7:0] bytes_v   [32];
    logic [7:0] idx_v     [32];

    decompress_1 dut (
        .clk           (clk),
        .reset         (reset),
        .set           (set),
        .readin        (readin),
        .readout       (readout),
        .full_in       (full_in),
        .decomp_din    (decomp_din),
        .in_index      (in_index),
        .decomp_dout_1 (decomp_dout_1),
        .decomp_dout_2 (decomp_dout_2),
        .out_index     (out_index),
        .readin_ok     (readin_ok),
        .readout_ok    (readout_ok),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Push the 128 expected pairs derived from the bench's own buffer model.
    task automatic push_expected();
        for (int k = 0; k < 128; k++) begin
            pair_t p;
            logic [7:0] b;
            int pos;
            b   = model_mem[k / 4];
            pos = (k % 4) * 2;
            p.idx = k;
            p.d1  = b[pos]     ? 16'd1665 : 16'd0;
            p.d2  = b[pos + 1] ? 16'd1665 : 16'd0;
            sb.push_back(p);
        end
    endtask

    // Stream 32 bytes: request in cycle i, data in cycle i+1, full_in with the last byte.
    task automatic load_msg();
        int guard;
        guard = 0;
        while (readin_ok !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        chk("load_wait_readin_ok", {31'd0, readin_ok}, 32'd1);
        for (int i = 0; i <= 32; i++) begin
            readin  = (i < 32);
            full_in = (i == 32);
            if (i >= 1) begin
                decomp_din = bytes_v[i - 1];
                in_index   = idx_v[i - 1];
                model_mem[idx_v[i - 1][4:0]] = bytes_v[i - 1];
            end
            tick();
        end
        readin  = 1'b0;
        full_in = 1'b0;
        chk("after_full_readin_ok", {31'd0, readin_ok}, 32'd0);
        chk("after_full_readout_ok", {31'd0, readout_ok}, 32'd1);
        push_expected();
    endtask

    // Consume pairs until the scoreboard empties or the front index equals stop_at.
    task automatic drain(input bit rnd, input int stop_at);
        int  guard;
        bit  ro;
        guard = 0;
        while (sb.size() > 0 && sb[0].idx != stop_at && guard < 3000) begin
            chk("drain_readout_ok", {31'd0, readout_ok}, 32'd1);
            chk("drain_out_index", {24'd0, out_index}, sb[0].idx);
            chk("drain_dout_1", {16'd0, decomp_dout_1}, {16'd0, sb[0].d1});
            chk("drain_dout_2", {16'd0, decomp_dout_2}, {16'd0, sb[0].d2});
            ro      = readout_ok;
            readout = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            if (readout && ro) begin
                void'(sb.pop_front());
            end
            guard++;
        end
        readout = 1'b0;
        if (guard >= 3000) begin
            chk("drain_timeout", 32'd1, 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1; set = 1'b0; readin = 1'b0; readout = 1'b0;
        full_in = 1'b0; decomp_din = 8'd0; in_index = 8'd0;
        for (int i = 0; i < 32; i++) model_mem[i] = 8'd0;
        tick();
        tick();
        chk("rst_out_index", {24'd0, out_index}, 32'd0);
        chk("rst_dout_1", {16'd0, decomp_dout_1}, 32'd0);
        chk("rst_dout_2", {16'd0, decomp_dout_2}, 32'd0);
        chk("rst_readin_ok", {31'd0, readin_ok}, 32'd0);
        chk("rst_readout_ok", {31'd0, readout_ok}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);

        reset = 1'b0;
        set   = 1'b1;
        tick();
        chk("idle_to_load_readin_ok", {31'd0, readin_ok}, 32'd1);

        // Single patterned byte, continuous consumption.
        for (int i = 0; i < 32; i++) begin
            bytes_v[i] = 8'h00;
            idx_v[i]   = 8'(i);
        end
        bytes_v[0] = 8'h9C;
        load_msg();
        drain(1'b0, 128);
        chk("a_done", {31'd0, done}, 32'd1);
        chk("a_done_readout_ok", {31'd0, readout_ok}, 32'd0);

        set = 1'b0;
        tick();
        chk("set_low_readin_ok", {31'd0, readin_ok}, 32'd0);
        chk("set_low_done", {31'd0, done}, 32'd0);
        chk("set_low_out_index", {24'd0, out_index}, 32'd0);
        set = 1'b1;
        tick();

        // All ones with random consumer gating.
        for (int i = 0; i < 32; i++) bytes_v[i] = 8'hFF;
        load_msg();
        drain(1'b1, 128);
        chk("b_done", {31'd0, done}, 32'd1);

        set = 1'b0;
        tick();
        set = 1'b1;
        tick();

        // Random bytes, wrapped index for byte 5, last byte 0x80.
        for (int i = 0; i < 32; i++) begin
            bytes_v[i] = 8'($urandom_range(0, 255));
            idx_v[i]   = 8'(i);
        end
        idx_v[5]    = 8'h25;
        bytes_v[5]  = 8'h03;
        bytes_v[31] = 8'h80;
        load_msg();
        chk("c_pair20_d1", {16'd0, sb[20].d1}, 32'd1665);
        chk("c_pair127_d2", {16'd0, sb[127].d2}, 32'd1665);
        drain(1'b1, 128);
        chk("c_done", {31'd0, done}, 32'd1);

        set = 1'b0;
        tick();
        set = 1'b1;
        tick();

        // Reset in the middle of output streaming.
        for (int i = 0; i < 32; i++) bytes_v[i] = 8'($urandom_range(0, 255));
        load_msg();
        drain(1'b1, 50);
        chk("d_at_50", {24'd0, out_index}, 32'd50);
        reset   = 1'b1;
        readout = 1'b1;
        readin  = 1'b1;
        full_in = 1'b1;
        tick();
        readout = 1'b0;
        readin  = 1'b0;
        full_in = 1'b0;
        chk("d_rst_out_index", {24'd0, out_index}, 32'd0);
        chk("d_rst_dout_1", {16'd0, decomp_dout_1}, 32'd0);
        chk("d_rst_dout_2", {16'd0, decomp_dout_2}, 32'd0);
        chk("d_rst_readout_ok", {31'd0, readout_ok}, 32'd0);
        chk("d_rst_readin_ok", {31'd0, readin_ok}, 32'd0);
        chk("d_rst_done", {31'd0, done}, 32'd0);
        sb.delete();
        reset = 1'b0;
        tick();
        chk("d_reload_readin_ok", {31'd0, readin_ok}, 32'd1);
        chk("d_reload_readout_ok", {31'd0, readout_ok}, 32'd0);

        set = 1'b0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decompress_1.md
DECOMPRESS_1 -- requirements
Module: decompress_1

Interface
REQ-001 SHALL have exactly one clock and one reset; reset is synchronous and active-high: clk and reset.
REQ-002 Ports SHALL be, one per line (name direction width meaning):
- clk input 1 rising-edge clock
- reset input 1 synchronous active-high reset
- set input 1 block enable; low holds block in IDLE
- readin input 1 producer requests to send message bytes
- readout input 1 consumer accepts current output pair
- full_in input 1 producer marks current byte as the last (index 31)
- decomp_din input 8 message byte
- in_index input 8 byte address; bits [4:0] used
- decomp_dout_1 output 16 even coefficient of current pair
- decomp_dout_2 output 16 odd coefficient of current pair
- out_index output 8 current pair index 0..127
- readin_ok output 1 block can accept bytes
- readout_ok output 1 current pair valid
- done output 1 all 128 pairs consumed
REQ-003 No parameters; constants N_BYTES=32, N_PAIRS=128, HALF_Q=1665 come from package.

Function
REQ-004 States SHALL be IDLE, LOAD, OUT, DONE.
REQ-005 IDLE->LOAD when set=1; any state->IDLE when set=0 (buffer kept, pair counter cleared).
REQ-006 readin_ok SHALL be 1 exactly in LOAD.
REQ-007 Handshake: cycle N with readin&readin_ok high registers a take flag; in cycle N+1 decomp_din is written to buffer[in_index[4:0]].
REQ-008 A write in the same cycle as full_in=1 SHALL still store the byte, then LOAD->OUT next edge; readin_ok drops that edge.
REQ-009 Bytes at in_index[7:5]!=0 SHALL still write using bits [4:0] (wrap-around).
REQ-010 In OUT, pair k (k=out_index) uses bits 2k and 2k+1 of the 256-bit message, byte k>>2, LSB first: bit=1 -> 1665, bit=0 -> 0.
REQ-011 decomp_dout_1 = coeff of bit 2k, decomp_dout_2 = coeff of bit 2k+1; outputs registered and valid whenever readout_ok=1.
REQ-012 readout_ok SHALL be 1 exactly in OUT; first pair valid on the first cycle after entry to OUT.
REQ-013 readout&readout_ok at an edge SHALL advance out_index by 1; readout low holds outputs stable.
REQ-014 Accepting pair 127 SHALL go OUT->DONE; done=1 and readout_ok=0 in DONE.
REQ-015 readin during OUT/DONE and readout during LOAD SHALL be ignored.

Reset
REQ-016 reset SHALL force IDLE, out_index=0, decomp_dout_1/2=0, readin_ok=0, readout_ok=0, done=0, take flag=0; buffer contents need not clear.
REQ-017 reset SHALL win over set, readin, readout and full_in on the same edge, including mid-LOAD and mid-OUT.

Configuration
REQ-018 Macro DECOMPRESS_1_AUTO_RESTART_EN: defined -> DONE returns to LOAD after one cycle (done pulses one cycle, out_index cleared); undefined -> DONE held until set=0 or reset.

Structure
REQ-019 Package decompress_1_pkg SHALL hold HALF_Q, N_BYTES, N_PAIRS and the state enum type.
REQ-020 One sub-module msg_buffer (32x8 register file, one write port, one combinational read port) SHALL hold the message.

Verification
REQ-021 Load byte0=0x9C, rest 0x00, readout=1 -> pairs 0..3 = (0,0),(1665,1665),(1665,0),(0,1665); pairs 4..127 = (0,0); done after 128 accepts.
REQ-022 All 32 bytes 0xFF -> every pair (1665,1665), out_index 0..127 in order.
REQ-023 Random readout gating -> outputs and out_index held when readout=0; no pair skipped or duplicated.
REQ-024 full_in with byte31=0x80 -> byte stored, pair 127 = (0,1665), readin_ok low the next cycle.
REQ-025 reset at out_index=50 -> all outputs 0, state IDLE; with set=1, LOAD and readin_ok=1 next cycle.
REQ-026 in_index=0x25 with data 0x03 -> buffer[5] written; pair 20 = (1665,1665).
